// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix codes, event field indices and receiver FSM states
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam int PS2_BREAK_BIT = 8;
    localparam int PS2_EXT_BIT = 9;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchroniser plus saturating glitch filter for one raw PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0] sync_q;
    logic level_q, level_d, disagree, flip;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        disagree = sync_q[1] != level_q;
        flip = disagree && cnt_q == CW'(FILTER_LEN - 1);
        cnt_d = (disagree && !flip) ? cnt_q + 1'b1 : '0;
        level_d = flip ? sync_q[1] : level_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            level_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            level_q <= level_d;
            cnt_q <= cnt_d;
        end
    end
    assign level = level_q;
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: filters PS/2 lines, deframes 11-bit frames and emits key events with E0/F0 flags
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] data_out,
    output logic       ready,
    output logic       frame_err
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic clk_f, data_f, clk_prev_q, sample, timeout, good;
    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic parity_q, parity_d, ready_q, ready_d, err_q, err_d, brk_q, brk_d, ext_q, ext_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [9:0] data_out_q, data_out_d;
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (.clk(clk), .reset_n(reset_n), .raw(ps2_clk), .level(clk_f));
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (.clk(clk), .reset_n(reset_n), .raw(ps2_data), .level(data_f));
    // A sample event in the expiry cycle suppresses the timeout
    assign sample = clk_prev_q && !clk_f;
    assign timeout = state_q != IDLE && !sample && wd_q >= WW'(TIMEOUT_CYCLES - 1);
    assign good = data_f && (^shift_q ^ parity_q);
    always_comb begin
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d = shift_q;
        parity_d = parity_q;
        data_out_d = data_out_q;
        ready_d = 1'b0;
        err_d = 1'b0;
        brk_d = brk_q;
        ext_d = ext_q;
        if (timeout) begin
            state_d = IDLE;
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (sample) begin
            case (state_q)
                IDLE: begin
                    state_d = data_f ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d = {data_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d = bit_cnt_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    parity_d = data_f;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!good) begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else if (shift_q == PS2_BREAK_PREFIX) begin
                        brk_d = 1'b1;
                    end else if (shift_q == PS2_EXT_PREFIX) begin
                        ext_d = 1'b1;
                    end else begin
                        data_out_d[7:0] = shift_q;
                        data_out_d[PS2_BREAK_BIT] = brk_q;
                        data_out_d[PS2_EXT_BIT] = ext_q;
                        ready_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
            endcase
        end
        wd_d = state_d == IDLE ? '0 : sample ? WW'(1) : wd_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
            state_q <= IDLE;
            bit_cnt_q <= '0;
            shift_q <= '0;
            parity_q <= 1'b0;
            wd_q <= '0;
            data_out_q <= '0;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else begin
            clk_prev_q <= clk_f;
            state_q <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q <= shift_d;
            parity_q <= parity_d;
            wd_q <= wd_d;
            data_out_q <= data_out_d;
            ready_q <= ready_d;
            err_q <= err_d;
            brk_q <= brk_d;
            ext_q <= ext_d;
        end
    end
    assign data_out = data_out_q;
    assign ready = ready_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: randomized PS/2 frames checked cycle by cycle against a scheduled event model
module tb_ps2_frame_receiver;
    localparam int F = 8;
    localparam int T = 200;
    logic clk = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [9:0] data_out;
    logic ready, frame_err;
    ps2_frame_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data_out(data_out), .ready(ready), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    typedef struct {int c; bit err; logic [9:0] v;} ev_t;
    ev_t evq[$];
    int cyc = 0, checks = 0, failures = 0;
    bit rst_last = 1'b1, brk_m = 1'b0, ext_m = 1'b0;
    logic [9:0] exp_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_last <= !reset_n;
    end
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        bit er, ee;
        er = 1'b0;
        ee = 1'b0;
        if (rst_last) begin
            exp_data = '0;
            evq.delete();
        end
        if (evq.size() > 0 && evq[0].c == cyc) begin
            er = !evq[0].err;
            ee = evq[0].err;
            if (er) exp_data = evq[0].v;
            void'(evq.pop_front());
        end
        chk("ready", 32'(ready), 32'(er));
        chk("frame_err", 32'(frame_err), 32'(ee));
        chk("data_out", 32'(data_out), 32'(exp_data));
    end
    // Strobe for a raw fall driven in cycle fc lands in cycle fc+3+F
    task automatic model_frame(logic [7:0] b, bit good, int c);
        if (!good) begin
            evq.push_back('{c: c, err: 1'b1, v: 10'h0});
            brk_m = 1'b0;
            ext_m = 1'b0;
        end else if (b == 8'hF0) brk_m = 1'b1;
        else if (b == 8'hE0) ext_m = 1'b1;
        else begin
            evq.push_back('{c: c, err: 1'b0, v: {ext_m, brk_m, b}});
            brk_m = 1'b0;
            ext_m = 1'b0;
        end
    endtask
    task automatic fall_bit(bit b, int half, int g, output int fc);
        @(negedge clk) ps2_data = b;
        if (g > 0) begin
            repeat (half - g - 3) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (2) @(negedge clk);
        end else repeat (half - 1) @(negedge clk);
        ps2_clk = 1'b0;
        fc = cyc;
    endtask
    task automatic rise(int half);
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask
    task automatic idle(int n);
        @(negedge clk) ps2_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask
    task automatic send_frame(logic [7:0] b, bit pflip, bit stop, int half, int gbit, int g);
        int fc;
        logic [10:0] fr;
        fr = {stop, ~^b ^ pflip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            fall_bit(fr[i], half, i == gbit ? g : 0, fc);
            if (i == 10) model_frame(b, !pflip && stop, fc + 3 + F);
            rise(half);
        end
        idle(10);
    endtask
    task automatic partial_frame(logic [7:0] b, int nbits, int half, output int fc);
        logic [10:0] fr;
        fr = {1'b1, ~^b, b, 1'b0};
        fc = 0;
        for (int i = 0; i < nbits; i++) begin
            fall_bit(fr[i], half, 0, fc);
            rise(half);
        end
        @(negedge clk) ps2_data = 1'b1;
    endtask
    initial begin
        int fc;
        repeat (5) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, 15, 99, 0);
        chk("lit_make_1C", 32'(data_out), 32'h01C);
        send_frame(8'hF0, 1'b0, 1'b1, 15, 99, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 15, 99, 0);
        chk("lit_break_11C", 32'(data_out), 32'h11C);
        send_frame(8'hE0, 1'b0, 1'b1, 16, 99, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 16, 99, 0);
        send_frame(8'h75, 1'b0, 1'b1, 16, 99, 0);
        chk("lit_ext_break_375", 32'(data_out), 32'h375);
        send_frame(8'hF0, 1'b0, 1'b1, 14, 99, 0);
        send_frame(8'h1C, 1'b1, 1'b1, 14, 99, 0);
        chk("lit_parity_hold", 32'(data_out), 32'h375);
        send_frame(8'h1B, 1'b0, 1'b1, 14, 99, 0);
        chk("lit_after_parity_1B", 32'(data_out), 32'h01B);
        send_frame(8'hF0, 1'b0, 1'b1, 15, 99, 0);
        partial_frame(8'h1C, 5, 15, fc);
        evq.push_back('{c: fc + 2 + F + T, err: 1'b1, v: 10'h0});
        brk_m = 1'b0;
        ext_m = 1'b0;
        idle(T + F + 40);
        send_frame(8'h1D, 1'b0, 1'b1, 15, 99, 0);
        chk("lit_after_timeout_1D", 32'(data_out), 32'h01D);
        @(negedge clk) ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        idle(20);
        send_frame(8'h23, 1'b0, 1'b1, 20, 4, 3);
        chk("lit_glitch_23", 32'(data_out), 32'h023);
        partial_frame(8'h2B, 5, 15, fc);
        reset_n = 1'b0;
        brk_m = 1'b0;
        ext_m = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        chk("lit_midreset_data", 32'(data_out), 32'h0);
        idle(F + 10);
        send_frame(8'h2B, 1'b0, 1'b1, 15, 99, 0);
        chk("lit_after_reset_2B", 32'(data_out), 32'h02B);
        for (int n = 0; n < 40; n++) begin
            int half, r;
            logic [7:0] b;
            half = int'($urandom_range(13, 25));
            r = int'($urandom_range(0, 99));
            b = r < 15 ? 8'hF0 : r < 25 ? 8'hE0 : 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 99) < 8, $urandom_range(0, 99) >= 5, half,
                       half >= 20 ? int'($urandom_range(0, 15)) : 99, int'($urandom_range(1, 5)));
            idle(int'($urandom_range(0, 30)));
        end
        repeat (50) @(negedge clk);
        chk("events_drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
